datatable_dpram: RTL and testbench

- True dual-port 1024 x 32 synchronous RAM holding the bridge command data table.
- Port A is the core-side access port; port B is the bridge-side access port (APF bridge window 0xF8xx2xxx, word address = byte address >> 2).
- Both ports share one clock. Both can read or write independently every cycle.

---
 rtl/datatable_dpram.sv | 69 ++++++
 tb/tb_datatable_dpram.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/datatable_dpram.sv
// True dual-port DATA_W x 2**ADDR_W RAM for the bridge command data table (port A core, port B bridge).
// Define DATATABLE_OUTREG_EN to add an output register stage (read latency 2 instead of 1).
module datatable_dpram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic              wren_a,
  output logic [DATA_W-1:0] q_a,
  input  logic [ADDR_W-1:0] address_b,
  input  logic [DATA_W-1:0] data_b,
  input  logic              wren_b,
  output logic [DATA_W-1:0] q_b
);

  localparam int DEPTH = 1 << ADDR_W;

  // Power-up contents are zero; this becomes the block-RAM init image.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;

  // NOTE: the array has no reset branch; a reset loop over 1024 words would stop block-RAM
  // inference. Port B's write comes second so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (wren_a) mem[address_a] <= data_a;
      if (wren_b) mem[address_b] <= data_b;
    end
  end

  // Reads see the pre-edge array (old data on a cross-port collision);
  // a port writing this cycle returns its own data (write-through).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_a <= '0;
      rd_b <= '0;
    end else begin
      rd_a <= wren_a ? data_a : mem[address_a];
      rd_b <= wren_b ? data_b : mem[address_b];
    end
  end

`ifdef DATATABLE_OUTREG_EN
  logic [DATA_W-1:0] q_a_r;
  logic [DATA_W-1:0] q_b_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_a_r <= '0;
      q_b_r <= '0;
    end else begin
      q_a_r <= rd_a;
      q_b_r <= rd_b;
    end
  end

  assign q_a = q_a_r;
  assign q_b = q_b_r;
`else
  assign q_a = rd_a;
  assign q_b = rd_b;
`endif

endmodule

// File: tb/tb_datatable_dpram.sv
// Self-checking bench for datatable_dpram: directed scenarios plus random traffic against
// an array model of the table. Honours DATATABLE_OUTREG_EN for the 2-cycle read latency.
module tb_datatable_dpram;

`ifdef DATATABLE_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        reset;
  logic [9:0]  address_a, address_b;
  logic [31:0] data_a, data_b;
  logic        wren_a, wren_b;
  logic [31:0] q_a, q_b;

  datatable_dpram dut (
    .clk       (clk),
    .reset     (reset),
    .address_a (address_a),
    .data_a    (data_a),
    .wren_a    (wren_a),
    .q_a       (q_a),
    .address_b (address_b),
    .data_b    (data_b),
    .wren_b    (wren_b),
    .q_b       (q_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: table contents plus the per-port read result expected at the outputs.
  logic [31:0] model_mem [1024];
  logic [31:0] pend_a, pend_b;
  logic [31:0] exp_a, exp_b;

  // Drive one cycle from a negedge, apply the table rules at the posedge, return at the next negedge.
  task automatic step(input logic wa, input logic [9:0] aa, input logic [31:0] da,
                      input logic wb, input logic [9:0] ab, input logic [31:0] db);
    logic [31:0] ra, rb;
    wren_a = wa; address_a = aa; data_a = da;
    wren_b = wb; address_b = ab; data_b = db;
    @(posedge clk);
    if (reset) begin
      ra = '0;
      rb = '0;
    end else begin
      ra = wa ? da : model_mem[aa];
      rb = wb ? db : model_mem[ab];
      if (wa) model_mem[aa] = da;
      if (wb) model_mem[ab] = db;
    end
    if (LAT == 2) begin
      exp_a  = reset ? 32'h0 : pend_a;
      exp_b  = reset ? 32'h0 : pend_b;
      pend_a = ra;
      pend_b = rb;
    end else begin
      exp_a = ra;
      exp_b = rb;
    end
    @(negedge clk);
  endtask

  // Repeat a read of the given addresses with writes off, to let the pipeline drain.
  task automatic hold(input logic [9:0] aa, input logic [9:0] ab, input int n);
    for (int i = 0; i < n; i++) step(1'b0, aa, 32'h0, 1'b0, ab, 32'h0);
  endtask

  task automatic clear_model_outputs();
    pend_a = '0; pend_b = '0; exp_a = '0; exp_b = '0;
  endtask

  task automatic test_reset();
    #1;
    n_total++; if (q_a !== 32'h0) $display("FAIL reset_async q_a got %h want %h", q_a, 32'h0); else n_pass++;
    n_total++; if (q_b !== 32'h0) $display("FAIL reset_async q_b got %h want %h", q_b, 32'h0); else n_pass++;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 10'd5, 32'h0, 1'b0, 10'd5, 32'h0);
      n_total++; if (q_a !== 32'h0) $display("FAIL reset_hold q_a got %h want %h", q_a, 32'h0); else n_pass++;
      n_total++; if (q_b !== 32'h0) $display("FAIL reset_hold q_b got %h want %h", q_b, 32'h0); else n_pass++;
    end
    reset = 1'b0;
    step(1'b0, 10'd0, 32'h0, 1'b0, 10'd0, 32'h0);
    hold(10'd0, 10'd0, LAT - 1);
    n_total++; if (q_a !== 32'h0) $display("FAIL reset_read0 q_a got %h want %h", q_a, 32'h0); else n_pass++;
    n_total++; if (q_b !== exp_b) $display("FAIL reset_read0 q_b got %h want %h", q_b, exp_b); else n_pass++;
  endtask

  task automatic test_cross_port();
    step(1'b1, 10'h3FF, 32'hDEADBEEF, 1'b0, 10'h000, 32'h0);
    step(1'b0, 10'h000, 32'h0, 1'b0, 10'h3FF, 32'h0);
    hold(10'h000, 10'h3FF, LAT - 1);
    n_total++; if (q_b !== 32'hDEADBEEF) $display("FAIL cross_port q_b got %h want %h", q_b, 32'hDEADBEEF); else n_pass++;
  endtask

  task automatic test_write_through();
    step(1'b0, 10'h000, 32'h0, 1'b1, 10'h010, 32'h12345678);
    hold(10'h000, 10'h010, LAT - 1);
    n_total++; if (q_b !== 32'h12345678) $display("FAIL write_through q_b got %h want %h", q_b, 32'h12345678); else n_pass++;
  endtask

  task automatic test_mixed_collision();
    step(1'b1, 10'h020, 32'h11111111, 1'b0, 10'h000, 32'h0);
    step(1'b1, 10'h020, 32'h22222222, 1'b0, 10'h020, 32'h0);
    hold(10'h000, 10'h020, LAT - 1);
    n_total++; if (q_b !== 32'h11111111) $display("FAIL mixed_old q_b got %h want %h", q_b, 32'h11111111); else n_pass++;
    hold(10'h000, 10'h020, 1);
    n_total++; if (q_b !== 32'h22222222) $display("FAIL mixed_new q_b got %h want %h", q_b, 32'h22222222); else n_pass++;
  endtask

  task automatic test_dual_write();
    step(1'b1, 10'h100, 32'hAAAA0000, 1'b1, 10'h100, 32'h0000BBBB);
    hold(10'h100, 10'h100, LAT - 1);
    n_total++; if (q_a !== 32'hAAAA0000) $display("FAIL dual_own q_a got %h want %h", q_a, 32'hAAAA0000); else n_pass++;
    n_total++; if (q_b !== 32'h0000BBBB) $display("FAIL dual_own q_b got %h want %h", q_b, 32'h0000BBBB); else n_pass++;
    hold(10'h100, 10'h100, LAT);
    n_total++; if (q_a !== 32'h0000BBBB) $display("FAIL dual_final q_a got %h want %h", q_a, 32'h0000BBBB); else n_pass++;
    n_total++; if (q_b !== 32'h0000BBBB) $display("FAIL dual_final q_b got %h want %h", q_b, 32'h0000BBBB); else n_pass++;
  endtask

  task automatic test_reset_mid();
    step(1'b1, 10'h001, 32'hCAFEF00D, 1'b0, 10'h001, 32'h0);
    step(1'b0, 10'h001, 32'h0, 1'b0, 10'h001, 32'h0);
    wren_a = 1'b1; address_a = 10'h001; data_a = 32'h0;
    #2 reset = 1'b1;
    clear_model_outputs();
    #1;
    n_total++; if (q_a !== 32'h0) $display("FAIL reset_mid_async q_a got %h want %h", q_a, 32'h0); else n_pass++;
    n_total++; if (q_b !== 32'h0) $display("FAIL reset_mid_async q_b got %h want %h", q_b, 32'h0); else n_pass++;
    @(negedge clk);
    step(1'b1, 10'h001, 32'h0, 1'b1, 10'h001, 32'h0);
    step(1'b1, 10'h001, 32'h0, 1'b0, 10'h001, 32'h0);
    n_total++; if (q_a !== 32'h0) $display("FAIL reset_mid_hold q_a got %h want %h", q_a, 32'h0); else n_pass++;
    reset = 1'b0;
    step(1'b0, 10'h001, 32'h0, 1'b0, 10'h001, 32'h0);
    hold(10'h001, 10'h001, LAT - 1);
    n_total++; if (q_a !== 32'hCAFEF00D) $display("FAIL reset_mid_keep q_a got %h want %h", q_a, 32'hCAFEF00D); else n_pass++;
    n_total++; if (q_b !== 32'hCAFEF00D) $display("FAIL reset_mid_keep q_b got %h want %h", q_b, 32'hCAFEF00D); else n_pass++;
  endtask

  task automatic test_idle_x();
    // Port B idle with unknown address/data must leave the table untouched.
    step(1'b0, 10'h3FF, 32'h0, 1'b0, 10'bx, 32'hx);
    hold(10'h3FF, 10'h020, LAT);
    n_total++; if (q_a !== 32'hDEADBEEF) $display("FAIL idle_x q_a got %h want %h", q_a, 32'hDEADBEEF); else n_pass++;
    n_total++; if (q_b !== 32'h22222222) $display("FAIL idle_x q_b got %h want %h", q_b, 32'h22222222); else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [9:0] aa, ab;
      // Narrow address pool so collisions of every kind occur often.
      aa = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 7));
      ab = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 7));
      step(($urandom_range(0, 2) == 0), aa, $urandom, ($urandom_range(0, 2) == 0), ab, $urandom);
      n_total++; if (q_a !== exp_a) $display("FAIL random[%0d] q_a got %h want %h", i, q_a, exp_a); else n_pass++;
      n_total++; if (q_b !== exp_b) $display("FAIL random[%0d] q_b got %h want %h", i, q_b, exp_b); else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) model_mem[i] = '0;
    clear_model_outputs();
    reset = 1'b1;
    wren_a = 1'b0; address_a = 10'd5; data_a = '0;
    wren_b = 1'b0; address_b = 10'd5; data_b = '0;
    test_reset();
    test_cross_port();
    test_write_through();
    test_mixed_collision();
    test_dual_write();
    test_reset_mid();
    test_idle_x();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
